circulant_row_accumulator: RTL and testbench
============================================

CIRCULANT_ROW_ACCUMULATOR -- requirements
Module: circulant_row_accumulator

Interface
REQ-001 SHALL have parameter MAXZ, default 81, maximum circulant size in bits (data width).
REQ-002 SHALL have parameter CNTW, default 8, width of the per-row beat counter.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data/in_last/z_size are valid; carries the fixed-latency-aligned valid from the circular-shifter output.
REQ-006 SHALL have port in_data, input, MAXZ bits: rotated circulant block from the upstream shifter.
REQ-007 SHALL have port in_last, input, 1 bit: final block of the current base-matrix row.
REQ-008 SHALL have port z_size, input, $clog2(MAXZ+1) bits: active lifting size Z for the row.
REQ-009 SHALL have port in_ready, output, 1 bit: beat is accepted when in_valid && in_ready.
REQ-010 SHALL have port out_data, output, MAXZ bits: XOR-accumulated row result.
REQ-011 SHALL have port out_count, output, CNTW bits: number of blocks accumulated into out_data.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data/out_count hold a result.
REQ-013 SHALL have port out_ready, input, 1 bit: result is consumed when out_valid && out_ready.
REQ-014 SHALL have port out_syn_ok, output, 1 bit: out_data is all-zero (see REQ-030).

Function
REQ-015 SHALL use states IDLE (no partial row) and ACCUM (partial row held in accumulator).
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-017 SHALL mask every accepted beat: bits [MAXZ-1:Zr] forced to 0, where Zr is the row's Z.
REQ-018 SHALL sample z_size into Zr on the first accepted beat in IDLE, hold it for the rest of the row, and ignore z_size on later beats.
REQ-019 SHALL treat z_size == 0 or z_size > MAXZ as MAXZ.
REQ-020 In IDLE, an accepted beat with in_last=0 SHALL load acc with the masked data, set count=1, and move to ACCUM.
REQ-021 In ACCUM, an accepted beat with in_last=0 SHALL set acc = acc XOR masked data and increment count.
REQ-022 An accepted beat with in_last=1 SHALL load out_data with (IDLE: masked data; ACCUM: acc XOR masked data), load out_count with count+1, set out_valid, clear acc and count, and enter IDLE.
REQ-023 Latency SHALL be exactly one cycle: out_valid rises on the edge that accepts the last beat.
REQ-024 out_data and out_count SHALL stay stable while out_valid && !out_ready.
REQ-025 On out handshake with no accepted last beat in the same cycle, out_valid SHALL clear next cycle.
REQ-026 If out handshake and an accepted last beat occur in the same cycle, the new result SHALL load and out_valid SHALL stay 1 (back-to-back, no bubble).
REQ-027 The counter SHALL saturate at 2^CNTW-1 and never wrap.
REQ-028 With in_valid=0, acc, count, state and Zr SHALL hold.

Reset
REQ-029 While rst=1: state=IDLE, acc=0, count=0, Zr=MAXZ, out_valid=0, out_data=0, out_count=0, out_syn_ok=0; a partial row in progress is discarded; in_ready reads 1 in the first cycle after reset.

Configuration
REQ-030 With macro CRA_SYNDROME_EN defined, out_syn_ok SHALL be registered with out_data and equal (result == 0); without it, out_syn_ok SHALL be tied to 0 and no comparator SHALL be built.

Verification
REQ-031 MAXZ=81, Z=81; beats 0x1, 0x3, 0x6 (last on the third) -> out_data=0x4, out_count=3, out_valid one cycle after the third accept.
REQ-032 Z=16; single beat in_data all-ones, in_last=1 -> out_data=0xFFFF, out_count=1; z_size changed to 8 mid-row in a 2-beat row -> mask stays 16.
REQ-033 Hold out_ready=0 with a result pending -> in_ready=0, out_data stable for 10 cycles; raise out_ready alongside a new last beat -> out_valid stays 1 and the new result appears next cycle.
REQ-034 CRA_SYNDROME_EN defined; beats 0xA5, 0xA5 (last on the second) -> out_data=0, out_syn_ok=1; undefined -> out_syn_ok=0.
REQ-035 Assert rst after 2 beats of a row; then send single last beat 0x7 -> out_data=0x7, out_count=1 (partial row discarded).

Source files
------------

// File: rtl/circulant_row_accumulator.sv
// XOR-accumulates masked circulant blocks of one base-matrix row; CRA_SYNDROME_EN adds a registered all-zero flag.
// Latency: result registered on the edge that accepts the last beat of a row.
// Backpressure: in_ready = !out_valid || out_ready; a pending result stalls input.
module circulant_row_accumulator #(
   parameter int MAXZ = 81,
   parameter int CNTW = 8
) (
   input  logic                       CLK,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [MAXZ-1:0]            in_data,
   input  logic                       in_last,
   input  logic [$clog2(MAXZ+1)-1:0]  z_size,
   output logic                       in_ready,
   output logic [MAXZ-1:0]            out_data,
   output logic [CNTW-1:0]            out_count,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_syn_ok
);

   localparam int ZW = $clog2(MAXZ+1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t            state;
   logic [MAXZ-1:0]   acc;
   logic [CNTW-1:0]   count;
   logic [ZW-1:0]     zr;

   logic              accept;
   logic [ZW-1:0]     z_eff;
   logic [ZW-1:0]     z_cur;
   logic [MAXZ-1:0]   mask;
   logic [MAXZ-1:0]   beat;
   logic [MAXZ-1:0]   result;
   logic [CNTW-1:0]   count_inc;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   // Out-of-range lifting sizes fall back to the full width.
   assign z_eff     = (z_size == '0 || z_size > ZW'(MAXZ)) ? ZW'(MAXZ) : z_size;
   assign z_cur     = (state == IDLE) ? z_eff : zr;
   assign mask      = ~({MAXZ{1'b1}} << z_cur);
   assign beat      = in_data & mask;
   assign result    = (state == IDLE) ? beat : (acc ^ beat);
   assign count_inc = (count == {CNTW{1'b1}}) ? count : count + 1'b1;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         zr        <= ZW'(MAXZ);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (state == IDLE) begin
               zr <= z_eff;
            end
            if (in_last) begin
               out_data  <= result;
               out_count <= count_inc;
               out_valid <= 1'b1;
               acc       <= '0;
               count     <= '0;
               state     <= IDLE;
            end else begin
               acc   <= result;
               count <= count_inc;
               state <= ACCUM;
            end
         end
      end
   end

`ifdef CRA_SYNDROME_EN
   logic syn_q;

   always_ff @(posedge CLK) begin
      if (rst) begin
         syn_q <= 1'b0;
      end else if (accept && in_last) begin
         syn_q <= (result == '0);
      end
   end

   assign out_syn_ok = syn_q;
`else
   assign out_syn_ok = 1'b0;
`endif

endmodule

// File: tb/tb_circulant_row_accumulator.sv
// Randomized and directed bench for circulant_row_accumulator against a row-level XOR model.
module tb_circulant_row_accumulator;

   localparam int MAXZ = 81;
   localparam int CNTW = 8;
   localparam int ZW   = $clog2(MAXZ+1);
   localparam int CMAX = (1 << CNTW) - 1;

   logic            CLK = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [MAXZ-1:0] in_data;
   logic            in_last;
   logic [ZW-1:0]   z_size;
   logic            in_ready;
   logic [MAXZ-1:0] out_data;
   logic [CNTW-1:0] out_count;
   logic            out_valid;
   logic            out_ready;
   logic            out_syn_ok;

   circulant_row_accumulator #(.MAXZ(MAXZ), .CNTW(CNTW)) dut (
      .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .z_size(z_size), .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_syn_ok(out_syn_ok)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   bit run    = 0;
   bit done   = 0;
   int rdy_mode = 1;  // 0 hold low, 1 hold high, 2 random, 3 driven by main

   // Row-level reference state
   bit              in_row;
   int              row_n;
   int              row_z;
   logic [MAXZ-1:0] row_x;
   bit              exp_valid;
   logic [MAXZ-1:0] exp_data;
   int              exp_count;
   bit              m_acc;

   task automatic chk_i(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_d(input string nm, input logic [MAXZ-1:0] act, input logic [MAXZ-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int eff_z(input int z);
      return (z == 0 || z > MAXZ) ? MAXZ : z;
   endfunction

   function automatic logic [MAXZ-1:0] mask_of(input int z);
      logic [MAXZ-1:0] m;
      for (int i = 0; i < MAXZ; i++) m[i] = (i < z);
      return m;
   endfunction

   function automatic logic [MAXZ-1:0] rand_data();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[MAXZ-1:0];
   endfunction

   always @(posedge CLK) begin
      if (rst) begin
         in_row = 0; row_n = 0; row_x = '0;
         exp_valid = 0; exp_data = '0; exp_count = 0;
      end else begin
         m_acc = !exp_valid || out_ready;
         if (exp_valid && out_ready) exp_valid = 0;
         if (in_valid && m_acc) begin
            if (!in_row) begin
               row_z = eff_z(int'(z_size)); row_x = '0; row_n = 0; in_row = 1;
            end
            row_x = row_x ^ (in_data & mask_of(row_z));
            row_n++;
            if (in_last) begin
               exp_valid = 1;
               exp_data  = row_x;
               exp_count = (row_n > CMAX) ? CMAX : row_n;
               in_row    = 0;
            end
         end
      end
      run = 1;
   end

   always @(negedge CLK) begin
      if (run && !done) begin
         chk_i("out_valid", int'(out_valid), int'(exp_valid));
         chk_i("in_ready", int'(in_ready), int'(!exp_valid || out_ready));
         if (exp_valid) begin
            chk_d("out_data", out_data, exp_data);
            chk_i("out_count", int'(out_count), exp_count);
`ifdef CRA_SYNDROME_EN
            chk_i("out_syn_ok", int'(out_syn_ok), int'(exp_data == '0));
`endif
         end
`ifndef CRA_SYNDROME_EN
         chk_i("out_syn_ok_tied", int'(out_syn_ok), 0);
`endif
      end
   end

   always @(posedge CLK) begin
      #1;
      if (rdy_mode == 0)      out_ready = 1'b0;
      else if (rdy_mode == 1) out_ready = 1'b1;
      else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send(input logic [MAXZ-1:0] d, input int z, input bit last);
      int t;
      bit ok;
      t = 0;
      in_valid = 1'b1; in_data = d; z_size = ZW'(z); in_last = last;
      do begin
         @(negedge CLK); ok = in_ready;
         @(posedge CLK); #1; t++;
      end while (!ok && t < 200);
      if (!ok) chk_i("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   logic [MAXZ-1:0] ones;
   int len;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      ones = '1;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; z_size = '0; out_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk_i("rst_out_valid", int'(out_valid), 0);
      chk_d("rst_out_data", out_data, '0);
      chk_i("rst_out_count", int'(out_count), 0);
      chk_i("rst_syn_ok", int'(out_syn_ok), 0);
      rst = 1'b0;
      @(posedge CLK); #1;
      chk_i("rst_in_ready", int'(in_ready), 1);

      // Three-beat full-width row
      rdy_mode = 0; idle(2);
      send(MAXZ'('h1), 81, 0);
      send(MAXZ'('h3), 81, 0);
      send(MAXZ'('h6), 81, 1);
      chk_i("r31_valid", int'(out_valid), 1);
      chk_d("r31_data", out_data, MAXZ'('h4));
      chk_i("r31_count", int'(out_count), 3);
      rdy_mode = 1; idle(2);

      // Z=16 masking, and Z held across the row
      rdy_mode = 0; idle(2);
      send(ones, 16, 1);
      chk_d("r32_mask16", out_data, MAXZ'('hFFFF));
      chk_i("r32_count1", int'(out_count), 1);
      rdy_mode = 1; idle(2);
      send(MAXZ'('hFF00), 16, 0);
      send(MAXZ'('h00F0), 8, 1);
      chk_d("r32_zhold", out_data, MAXZ'('hFFF0));

      // Z out of range falls back to MAXZ
      send(ones, 0, 1);
      chk_d("z0_full", out_data, ones);
      send(ones, 100, 1);
      chk_d("z100_full", out_data, ones);
      idle(2);

      // Backpressure hold, then back-to-back handshake
      rdy_mode = 0; idle(2);
      send(MAXZ'('h5), 81, 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         chk_i("r33_in_ready", int'(in_ready), 0);
         chk_d("r33_stable", out_data, MAXZ'('h5));
      end
      rdy_mode = 3; out_ready = 1'b1;
      send(MAXZ'('h9), 81, 1);
      chk_i("r33_b2b_valid", int'(out_valid), 1);
      chk_d("r33_b2b_data", out_data, MAXZ'('h9));
      rdy_mode = 1; idle(2);

      // Syndrome-zero row
      send(MAXZ'('hA5), 81, 0);
      send(MAXZ'('hA5), 81, 1);
      chk_d("r34_data", out_data, '0);
`ifdef CRA_SYNDROME_EN
      chk_i("r34_syn", int'(out_syn_ok), 1);
`else
      chk_i("r34_syn", int'(out_syn_ok), 0);
`endif
      idle(2);

      // Reset discards a partial row
      send(MAXZ'('h30), 81, 0);
      send(MAXZ'('h11), 81, 0);
      rst = 1'b1; @(posedge CLK); #1; rst = 1'b0;
      send(MAXZ'('h7), 81, 1);
      chk_d("r35_data", out_data, MAXZ'('h7));
      chk_i("r35_count", int'(out_count), 1);
      idle(2);

      // Counter saturation
      for (int i = 0; i < 299; i++) send(rand_data(), 81, 0);
      send(rand_data(), 81, 1);
      chk_i("sat_count", int'(out_count), CMAX);
      idle(2);

      // Randomized rows, gaps, Z values and backpressure
      rdy_mode = 2;
      for (int r = 0; r < 150; r++) begin
         len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            send(rand_data(), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(1, 81),
                 b == len - 1);
            idle($urandom_range(0, 2));
         end
      end

      rdy_mode = 1; idle(5);
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
